multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the multicycle RV32I datapath (PC/IR/MDR/A/B/ALUOut registers, shared instruction/data memory, register bank, ALU).
- Decodes the current IR contents and drives every datapath strobe and mux select, one state per cycle.
- Adds configurable memory wait states, an illegal-instruction flag, and a retired-instruction counter for FPGA debug.

Parameters:
MEM_WAIT, 0, extra cycles held in each memory-access state (FETCH, MEMRD, MEMWR); 0 to 7.

Ports:
iCLK  in  1  CPU clock; all state changes on rising edge.
iRST  in  1  asynchronous active-low reset.
iInst  in  32  current IR contents from the datapath.
oRegWrite  out  1  register bank write enable.
oALUSrcA  out  2  ALU A select: 00 PC, 01 A, 10 PCBack (PC of the current instruction).
oALUSrcB  out  2  ALU B select: 00 B, 01 constant 4, 10 immediate.
oMemRead  out  1  memory read enable.
oMemWrite  out  1  memory write enable.
oMemtoReg  out  1  register write-data select: 0 ALUOut, 1 MDR.
oIoD  out  1  memory address select: 0 PC, 1 ALUOut.
oIRWrite  out  1  IR load (also loads PCBack from PC).
oPCWrite  out  1  unconditional PC load.
oPCWriteCond  out  1  PC load qualified by ALU zero in the datapath.
oALUOp  out  2  00 add, 01 sub (branch compare), 10 decode from funct3/funct7.
oPCSource  out  1  PC source: 0 ALU result, 1 ALUOut.
oIllegal  out  1  one-cycle pulse on an unsupported instruction.
oState  out  4  current state encoding (debug).
oInstrCount  out  32  retired-instruction count.

Behaviour:
- Reset:
  - While iRST=0: state=FETCH, wait counter=0, oInstrCount=0.
  - All strobes (RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, Illegal) are forced to 0.
  - Selects read 0.
  - Reset mid-instruction aborts it; no partial strobes follow.
- Outputs depend on state only. Any signal not listed for a state is 0.
- States and outputs:
  - 0 FETCH: MemRead=1, IoD=0, SrcA=00, SrcB=01, ALUOp=00. IRWrite=1 and PCWrite=1 (PCSource=0) are asserted only in the last wait cycle.
  - 1 DECODE: SrcA=10, SrcB=10, ALUOp=00; ALUOut receives the branch target.
  - 2 MEMADR: SrcA=01, SrcB=10, ALUOp=00.
  - 3 MEMRD: MemRead=1, IoD=1.
  - 4 MEMWB: RegWrite=1, MemtoReg=1.
  - 5 MEMWR: MemWrite=1, IoD=1.
  - 6 EXEC_R: SrcA=01, SrcB=00, ALUOp=10.
  - 7 EXEC_I: SrcA=01, SrcB=10, ALUOp=10.
  - 8 ALUWB: RegWrite=1, MemtoReg=0.
  - 9 BRANCH: SrcA=01, SrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1.
  - 10 ILLEGAL: Illegal=1.
- Transitions:
  - FETCH -> DECODE after MEM_WAIT+1 cycles.
  - DECODE dispatches on opcode iInst[6:0]:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 with funct3=000 -> BRANCH
    - anything else (including branch funct3≠000) -> ILLEGAL
  - MEMADR -> MEMRD if opcode=0000011 and funct3=010; -> MEMWR if opcode=0100011 and funct3=010; otherwise -> ILLEGAL.
  - MEMRD -> MEMWB after MEM_WAIT+1 cycles.
  - MEMWR -> FETCH after MEM_WAIT+1 cycles.
  - EXEC_R and EXEC_I -> ALUWB.
  - MEMWB, ALUWB, BRANCH, ILLEGAL -> FETCH.
- Wait counter:
  - 3-bit, cleared on entry to each memory state.
  - Memory strobes (MemRead/MemWrite, IoD) are held constant for all MEM_WAIT+1 cycles; repeated writes of identical data are acceptable.
- Latency with MEM_WAIT=0:
  - R/I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - Illegal: 3 cycles.
  - Each memory state adds MEM_WAIT cycles.
- oInstrCount:
  - Increments by 1 on the edge leaving MEMWB, MEMWR (last cycle), ALUWB or BRANCH.
  - Not incremented for ILLEGAL.
  - Wraps 0xFFFFFFFF -> 0.
- iInst is sampled only in DECODE and MEMADR; IR is stable there because IRWrite is 0 outside FETCH.
- rd=x0 writes are still strobed; the register bank discards them.
- Unused state encodings 11-15 -> FETCH next cycle, with all strobes 0.

Test Plan:
- add x3,x1,x2 (0x002081B3), MEM_WAIT=0 -> states 0,1,6,8,0. RegWrite=1, MemtoReg=0 only in cycle 4. oInstrCount 0->1.
- lw x5,8(x0) (0x00802283) -> states 0,1,2,3,4. MEMRD has IoD=1, MemRead=1. MEMWB has RegWrite=1, MemtoReg=1. Count +1.
- sw x5,12(x0) (0x00502623) -> states 0,1,2,5. MemWrite=1, IoD=1 in cycle 4 only. RegWrite never asserted.
- beq x0,x0,-8 (0xFE000CE3) -> DECODE drives SrcA=10, SrcB=10. BRANCH drives PCWriteCond=1, PCSource=1, ALUOp=01. 3 cycles total.
- Opcode 0x0000007F -> ILLEGAL in cycle 3, oIllegal high exactly 1 cycle, then FETCH. Count unchanged. Also bne (0xFE001CE3) -> ILLEGAL.
- MEM_WAIT=2, lw -> FETCH lasts 3 cycles with IRWrite/PCWrite only in the third; MEMRD lasts 3 cycles. Then assert iRST=0 during MEMRD -> all strobes 0 immediately, state=FETCH, count=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I datapath: decodes IR, sequences
// every datapath strobe, inserts memory wait states and counts retired instructions.
module multicycle_control #(
  parameter int MEM_WAIT = 0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iInst,
  output logic        oRegWrite,
  output logic [1:0]  oALUSrcA,
  output logic [1:0]  oALUSrcB,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oMemtoReg,
  output logic        oIoD,
  output logic        oIRWrite,
  output logic        oPCWrite,
  output logic        oPCWriteCond,
  output logic [1:0]  oALUOp,
  output logic        oPCSource,
  output logic        oIllegal,
  output logic [3:0]  oState,
  output logic [31:0] oInstrCount
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ILLEGAL = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] LAST_WAIT = 3'(MEM_WAIT);

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] count_q, count_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        last_wait;
  logic        in_mem_state;

  assign opcode       = iInst[6:0];
  assign funct3       = iInst[14:12];
  assign last_wait    = (wait_q == LAST_WAIT);
  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= S_FETCH;
      wait_q  <= 3'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (last_wait) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LOAD || opcode == OP_STORE)        state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)                        state_d = S_EXEC_R;
        else if (opcode == OP_ITYPE)                        state_d = S_EXEC_I;
        else if (opcode == OP_BRANCH && funct3 == 3'b000)   state_d = S_BRANCH;
        else                                                state_d = S_ILLEGAL;
      end
      S_MEMADR: begin
        if (opcode == OP_LOAD && funct3 == 3'b010)          state_d = S_MEMRD;
        else if (opcode == OP_STORE && funct3 == 3'b010)    state_d = S_MEMWR;
        else                                                state_d = S_ILLEGAL;
      end
      S_MEMRD:  if (last_wait) state_d = S_MEMWB;
      S_MEMWR:  if (last_wait) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ILLEGAL: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Memory states are never re-entered back to back, so the counter only
  // needs to run while parked in one and clears on every exit.
  always_comb begin
    wait_d = 3'd0;
    if (in_mem_state && !last_wait) wait_d = wait_q + 3'd1;
  end

  always_comb begin
    count_d = count_q;
    if (state_q == S_MEMWB || state_q == S_ALUWB || state_q == S_BRANCH ||
        (state_q == S_MEMWR && last_wait))
      count_d = count_q + 32'd1;
  end

  // Outputs are a function of state only, forced quiet while reset is held.
  always_comb begin
    oRegWrite    = 1'b0;
    oALUSrcA     = 2'b00;
    oALUSrcB     = 2'b00;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oMemtoReg    = 1'b0;
    oIoD         = 1'b0;
    oIRWrite     = 1'b0;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oALUOp       = 2'b00;
    oPCSource    = 1'b0;
    oIllegal     = 1'b0;
    if (iRST) begin
      case (state_q)
        S_FETCH: begin
          oMemRead = 1'b1;
          oALUSrcB = 2'b01;
          oIRWrite = last_wait;
          oPCWrite = last_wait;
        end
        S_DECODE: begin
          oALUSrcA = 2'b10;
          oALUSrcB = 2'b10;
        end
        S_MEMADR: begin
          oALUSrcA = 2'b01;
          oALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          oMemRead = 1'b1;
          oIoD     = 1'b1;
        end
        S_MEMWB: begin
          oRegWrite = 1'b1;
          oMemtoReg = 1'b1;
        end
        S_MEMWR: begin
          oMemWrite = 1'b1;
          oIoD      = 1'b1;
        end
        S_EXEC_R: begin
          oALUSrcA = 2'b01;
          oALUOp   = 2'b10;
        end
        S_EXEC_I: begin
          oALUSrcA = 2'b01;
          oALUSrcB = 2'b10;
          oALUOp   = 2'b10;
        end
        S_ALUWB:  oRegWrite = 1'b1;
        S_BRANCH: begin
          oALUSrcA     = 2'b01;
          oALUOp       = 2'b01;
          oPCWriteCond = 1'b1;
          oPCSource    = 1'b1;
        end
        S_ILLEGAL: oIllegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign oState      = state_q;
  assign oInstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: two instances (MEM_WAIT 0 and 2)
// checked cycle by cycle against an instruction-level sequence model.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst0_n, rst2_n;
  logic [31:0] inst0, inst2;

  logic        rw0, mr0, mw0, m2r0, iod0, irw0, pcw0, pcc0, pcs0, ill0;
  logic [1:0]  sa0, sb0, op0;
  logic [3:0]  st0;
  logic [31:0] cnt0;
  logic        rw2, mr2, mw2, m2r2, iod2, irw2, pcw2, pcc2, pcs2, ill2;
  logic [1:0]  sa2, sb2, op2;
  logic [3:0]  st2;
  logic [31:0] cnt2;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT(0)) dut0 (
    .iCLK(clk), .iRST(rst0_n), .iInst(inst0),
    .oRegWrite(rw0), .oALUSrcA(sa0), .oALUSrcB(sb0), .oMemRead(mr0),
    .oMemWrite(mw0), .oMemtoReg(m2r0), .oIoD(iod0), .oIRWrite(irw0),
    .oPCWrite(pcw0), .oPCWriteCond(pcc0), .oALUOp(op0), .oPCSource(pcs0),
    .oIllegal(ill0), .oState(st0), .oInstrCount(cnt0));

  multicycle_control #(.MEM_WAIT(2)) dut2 (
    .iCLK(clk), .iRST(rst2_n), .iInst(inst2),
    .oRegWrite(rw2), .oALUSrcA(sa2), .oALUSrcB(sb2), .oMemRead(mr2),
    .oMemWrite(mw2), .oMemtoReg(m2r2), .oIoD(iod2), .oIRWrite(irw2),
    .oPCWrite(pcw2), .oPCWriteCond(pcc2), .oALUOp(op2), .oPCSource(pcs2),
    .oIllegal(ill2), .oState(st2), .oInstrCount(cnt2));

  // Control bundle order: RegWrite SrcA SrcB MemRead MemWrite MemtoReg IoD
  // IRWrite PCWrite PCWriteCond ALUOp PCSource Illegal
  logic [15:0] obs0, obs2;
  assign obs0 = {rw0, sa0, sb0, mr0, mw0, m2r0, iod0, irw0, pcw0, pcc0, op0, pcs0, ill0};
  assign obs2 = {rw2, sa2, sb2, mr2, mw2, m2r2, iod2, irw2, pcw2, pcc2, op2, pcs2, ill2};

  typedef struct {
    int          st;
    logic [15:0] ctrl;
    bit          retire;
  } step_t;

  step_t       exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] model_cnt0 = 0;
  logic [31:0] model_cnt2 = 0;

  function automatic logic [15:0] mk(bit rw, logic [1:0] sa, logic [1:0] sb,
                                     bit mr, bit mw, bit m2r, bit iod, bit irw,
                                     bit pcw, bit pcc, logic [1:0] aop, bit pcs,
                                     bit ill);
    return {rw, sa, sb, mr, mw, m2r, iod, irw, pcw, pcc, aop, pcs, ill};
  endfunction

  task automatic push(int st, logic [15:0] ctrl, bit retire);
    step_t s;
    s.st = st; s.ctrl = ctrl; s.retire = retire;
    exp_q.push_back(s);
  endtask

  // Expected cycle-by-cycle trace of one instruction, built from its fields.
  task automatic build_expected(logic [31:0] inst, int mw);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = inst[6:0];
    f3  = inst[14:12];
    exp_q.delete();
    for (int k = 0; k <= mw; k++)
      push(0, mk(0, 2'b00, 2'b01, 1, 0, 0, 0, k == mw, k == mw, 0, 2'b00, 0, 0), 0);
    push(1, mk(0, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), 0);
    if (opc == 7'b0000011 || opc == 7'b0100011) begin
      push(2, mk(0, 2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), 0);
      if (opc == 7'b0000011 && f3 == 3'b010) begin
        for (int k = 0; k <= mw; k++)
          push(3, mk(0, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0), 0);
        push(4, mk(1, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0), 1);
      end else if (opc == 7'b0100011 && f3 == 3'b010) begin
        for (int k = 0; k <= mw; k++)
          push(5, mk(0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0), k == mw);
      end else begin
        push(10, mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1), 0);
      end
    end else if (opc == 7'b0110011) begin
      push(6, mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0), 0);
      push(8, mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1);
    end else if (opc == 7'b0010011) begin
      push(7, mk(0, 2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0), 0);
      push(8, mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1);
    end else if (opc == 7'b1100011 && f3 == 3'b000) begin
      push(9, mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b01, 1, 0), 1);
    end else begin
      push(10, mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1), 0);
    end
  endtask

  // Called at a falling edge with the selected DUT sitting in FETCH.
  task automatic run_instr(int which, logic [31:0] inst, string tag);
    int          mw;
    logic [15:0] o;
    logic [3:0]  s;
    logic [31:0] c, mc;
    mw = (which == 2) ? 2 : 0;
    build_expected(inst, mw);
    if (which == 2) inst2 = inst; else inst0 = inst;
    foreach (exp_q[i]) begin
      #1;
      o  = (which == 2) ? obs2 : obs0;
      s  = (which == 2) ? st2  : st0;
      c  = (which == 2) ? cnt2 : cnt0;
      mc = (which == 2) ? model_cnt2 : model_cnt0;
      n_total++;
      if (s !== 4'(exp_q[i].st))
        $display("[TB] FAIL %s cyc%0d state: got %0d want %0d", tag, i, s, exp_q[i].st);
      else n_pass++;
      n_total++;
      if (o !== exp_q[i].ctrl)
        $display("[TB] FAIL %s cyc%0d ctrl: got %b want %b", tag, i, o, exp_q[i].ctrl);
      else n_pass++;
      n_total++;
      if (c !== mc)
        $display("[TB] FAIL %s cyc%0d count: got %0d want %0d", tag, i, c, mc);
      else n_pass++;
      if (exp_q[i].retire) begin
        if (which == 2) model_cnt2++; else model_cnt0++;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] b;
    logic [2:0]  f3;
    b = $urandom;
    case ($urandom_range(0, 7))
      0: return {b[31:7], 7'b0110011};
      1: return {b[31:7], 7'b0010011};
      2: return {b[31:15], 3'b010, b[11:7], 7'b0000011};
      3: return {b[31:15], 3'b010, b[11:7], 7'b0100011};
      4: return {b[31:15], 3'b000, b[11:7], 7'b1100011};
      5: begin
        f3 = 3'($urandom_range(1, 7));
        return {b[31:15], f3, b[11:7], 7'b1100011};
      end
      6: begin
        f3 = b[14:12];
        if (f3 == 3'b010) f3 = 3'b011;
        return {b[31:15], f3, b[11:7], b[5] ? 7'b0100011 : 7'b0000011};
      end
      default: return b;
    endcase
  endfunction

  task automatic test_reset();
    rst0_n = 1'b0; rst2_n = 1'b0;
    inst0 = 32'h002081B3; inst2 = 32'h002081B3;
    repeat (2) @(negedge clk);
    n_total++;
    if (obs0 !== 16'd0) $display("[TB] FAIL reset ctrl0: got %b want 0", obs0); else n_pass++;
    n_total++;
    if (st0 !== 4'd0) $display("[TB] FAIL reset state0: got %0d want 0", st0); else n_pass++;
    n_total++;
    if (cnt0 !== 32'd0) $display("[TB] FAIL reset count0: got %0d want 0", cnt0); else n_pass++;
    n_total++;
    if (obs2 !== 16'd0) $display("[TB] FAIL reset ctrl2: got %b want 0", obs2); else n_pass++;
    n_total++;
    if (st2 !== 4'd0) $display("[TB] FAIL reset state2: got %0d want 0", st2); else n_pass++;
    n_total++;
    if (cnt2 !== 32'd0) $display("[TB] FAIL reset count2: got %0d want 0", cnt2); else n_pass++;
  endtask

  task automatic test_directed();
    rst0_n = 1'b1;
    run_instr(0, 32'h002081B3, "add");
    run_instr(0, 32'h00802283, "lw");
    run_instr(0, 32'h00502623, "sw");
    run_instr(0, 32'hFE000CE3, "beq");
    run_instr(0, 32'h0000007F, "illegal_op");
    run_instr(0, 32'hFE001CE3, "bne");
    run_instr(0, 32'h00800283, "lb");
    run_instr(0, 32'h00A00093, "addi");
  endtask

  task automatic test_random(int which, int n);
    for (int i = 0; i < n; i++) run_instr(which, rand_inst(), "rand");
  endtask

  task automatic test_mem_wait();
    rst0_n = 1'b0;
    rst2_n = 1'b1;
    run_instr(2, 32'h00802283, "lw_w2");
    run_instr(2, 32'h00502623, "sw_w2");
    run_instr(2, 32'h002081B3, "add_w2");
    run_instr(2, 32'h0000007F, "ill_w2");
  endtask

  task automatic test_reset_mid();
    int guard;
    inst2 = 32'h00802283;
    guard = 0;
    while (st2 !== 4'd3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_total++;
    if (st2 !== 4'd3) $display("[TB] FAIL midreset reach MEMRD: got %0d want 3", st2);
    else n_pass++;
    @(negedge clk);
    rst2_n = 1'b0;
    #1;
    n_total++;
    if (obs2 !== 16'd0) $display("[TB] FAIL midreset ctrl: got %b want 0", obs2); else n_pass++;
    n_total++;
    if (st2 !== 4'd0) $display("[TB] FAIL midreset state: got %0d want 0", st2); else n_pass++;
    n_total++;
    if (cnt2 !== 32'd0) $display("[TB] FAIL midreset count: got %0d want 0", cnt2); else n_pass++;
    model_cnt2 = 0;
    repeat (2) @(negedge clk);
    n_total++;
    if (obs2 !== 16'd0) $display("[TB] FAIL held reset ctrl: got %b want 0", obs2); else n_pass++;
    rst2_n = 1'b1;
    run_instr(2, 32'h002081B3, "add_after_rst");
    n_total++;
    if (cnt2 !== 32'd1) $display("[TB] FAIL count after rst: got %0d want 1", cnt2); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(0, 60);
    test_mem_wait();
    test_random(2, 25);
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
